// File: rtl/ddr3_init.sv
// ddr3_init: DDR3 power-up sequencer (RESET#, CKE, MR2/MR3/MR1/MR0, ZQCL).
// Build option: DDR3_INIT_SHORT_DELAYS_EN shortens the RESET#/CKE/ZQ waits.
module ddr3_init #(
    parameter int DDR_FREQ_MHZ = 100,
    parameter int DDR_ROW_BITS = 15,
    parameter int DDR_CAS_LAT  = 6,
    parameter int DDR_CWL      = 6,
    parameter int DDR_WR_RECOV = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    ddr_reset_n_o,
    output logic                    enable_o,
    output logic                    req_o,
    input  logic                    accept_i,
    output logic [3:0]              command_o,
    output logic [2:0]              bank_o,
    output logic [DDR_ROW_BITS-1:0] addr_o,
    output logic                    done_o
);

    function automatic int f_min1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

`ifdef DDR3_INIT_SHORT_DELAYS_EN
    localparam int T_RST = 16;
    localparam int T_CKE = 32;
    localparam int T_ZQI = 16;
`else
    localparam int T_RST = f_min1(200 * DDR_FREQ_MHZ);
    localparam int T_CKE = f_min1(500 * DDR_FREQ_MHZ);
    localparam int T_ZQI = 512;
`endif
    localparam int T_XPR = f_min1((120 * DDR_FREQ_MHZ + 999) / 1000);
    localparam int T_MRD = 4;
    localparam int T_MOD = 12;

    localparam int T_MAX = f_max(f_max(T_RST, T_CKE), f_max(T_XPR, T_ZQI));
    localparam int TW    = $clog2(T_MAX + 1);

    // Entry waits last T cycles; post-command waits make the next command
    // land exactly T cycles after the accepted one.
    localparam logic [TW-1:0] L_RST = TW'(T_RST - 1);
    localparam logic [TW-1:0] L_CKE = TW'(T_CKE - 1);
    localparam logic [TW-1:0] L_XPR = TW'(T_XPR - 1);
    localparam logic [TW-1:0] L_MRD = TW'(f_max(T_MRD - 2, 0));
    localparam logic [TW-1:0] L_MOD = TW'(f_max(T_MOD - 2, 0));
    localparam logic [TW-1:0] L_ZQI = TW'(f_max(T_ZQI - 2, 0));

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ZQCL = 4'b0110;

    localparam int RB = DDR_ROW_BITS;
    localparam logic [RB-1:0] MR2_VAL = RB'((DDR_CWL - 5) << 3);
    localparam logic [RB-1:0] MR1_VAL = RB'(1 << 2);
    localparam logic [RB-1:0] MR0_VAL = RB'(2 | ((DDR_CAS_LAT - 4) << 4)
                                        | (1 << 8)
                                        | ((DDR_WR_RECOV - 4) << 9));
    localparam logic [RB-1:0] ZQ_VAL  = RB'(1 << 10);

    typedef enum logic [3:0] {
        ST_RESET, ST_CKE_WAIT, ST_XPR,
        ST_MR2, ST_MR3, ST_MR1, ST_MR0, ST_ZQCL,
        ST_WAIT, ST_DONE
    } state_t;

    state_t          r_state;
    state_t          r_next;
    logic [TW-1:0]   r_timer;

    state_t          w_succ;
    logic [TW-1:0]   w_ld;
    logic [3:0]      w_cmd;
    logic [2:0]      w_bank;
    logic [RB-1:0]   w_addr;

    // Successor command and post-accept wait for the command being issued.
    always_comb begin
        w_succ = ST_DONE;
        w_ld   = L_MRD;
        case (r_state)
            ST_MR2:  w_succ = ST_MR3;
            ST_MR3:  w_succ = ST_MR1;
            ST_MR1:  w_succ = ST_MR0;
            ST_MR0: begin
                w_succ = ST_ZQCL;
                w_ld   = L_MOD;
            end
            ST_ZQCL: begin
                w_succ = ST_DONE;
                w_ld   = L_ZQI;
            end
            default: ;
        endcase
    end

    // Command payload to present when the wait for r_next expires.
    always_comb begin
        w_cmd  = CMD_MRS;
        w_bank = 3'd0;
        w_addr = '0;
        case (r_next)
            ST_MR3:  w_bank = 3'd3;
            ST_MR1: begin
                w_bank = 3'd1;
                w_addr = MR1_VAL;
            end
            ST_MR0:  w_addr = MR0_VAL;
            ST_ZQCL: begin
                w_cmd  = CMD_ZQCL;
                w_addr = ZQ_VAL;
            end
            default: ;
        endcase
    end

    // Init sequencer: timed waits, command handshakes, sticky done.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_RESET;
            r_next        <= ST_MR3;
            r_timer       <= L_RST;
            ddr_reset_n_o <= 1'b0;
            enable_o      <= 1'b0;
            req_o         <= 1'b0;
            command_o     <= CMD_NOP;
            bank_o        <= 3'd0;
            addr_o        <= '0;
            done_o        <= 1'b0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    if (r_timer == '0) begin
                        ddr_reset_n_o <= 1'b1;
                        r_timer       <= L_CKE;
                        r_state       <= ST_CKE_WAIT;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                ST_CKE_WAIT: begin
                    if (r_timer == '0) begin
                        enable_o <= 1'b1;
                        r_timer  <= L_XPR;
                        r_state  <= ST_XPR;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                ST_XPR: begin
                    if (r_timer == '0) begin
                        req_o     <= 1'b1;
                        command_o <= CMD_MRS;
                        bank_o    <= 3'd2;
                        addr_o    <= MR2_VAL;
                        r_state   <= ST_MR2;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                ST_MR2, ST_MR3, ST_MR1, ST_MR0, ST_ZQCL: begin
                    if (accept_i) begin
                        req_o     <= 1'b0;
                        command_o <= CMD_NOP;
                        bank_o    <= 3'd0;
                        addr_o    <= '0;
                        r_timer   <= w_ld;
                        r_next    <= w_succ;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_timer == '0) begin
                        r_state <= r_next;
                        if (r_next == ST_DONE) begin
                            done_o <= 1'b1;
                        end else begin
                            req_o     <= 1'b1;
                            command_o <= w_cmd;
                            bank_o    <= w_bank;
                            addr_o    <= w_addr;
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                ST_DONE: ;
                default: r_state <= ST_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_init.sv
// tb_ddr3_init: directed checks of the DDR3 power-up sequencer.
// Works with DDR3_INIT_SHORT_DELAYS_EN defined (F=100) or undefined (F=1).
module tb_ddr3_init;

`ifdef DDR3_INIT_SHORT_DELAYS_EN
    localparam int F     = 100;
    localparam int E_RST = 16;
    localparam int E_CKE = 32;
    localparam int E_XPR = 12;
    localparam int E_ZQI = 16;
`else
    localparam int F     = 1;
    localparam int E_RST = 200;
    localparam int E_CKE = 500;
    localparam int E_XPR = 1;
    localparam int E_ZQI = 512;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        accept_i = 1'b0;
    logic        ddr_reset_n_o;
    logic        enable_o;
    logic        req_o;
    logic        done_o;
    logic [3:0]  command_o;
    logic [2:0]  bank_o;
    logic [14:0] addr_o;

    int checks = 0;
    int failures = 0;

    ddr3_init #(
        .DDR_FREQ_MHZ(F),
        .DDR_ROW_BITS(15),
        .DDR_CAS_LAT (6),
        .DDR_CWL     (6),
        .DDR_WR_RECOV(6)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ddr_reset_n_o(ddr_reset_n_o),
        .enable_o     (enable_o),
        .req_o        (req_o),
        .accept_i     (accept_i),
        .command_o    (command_o),
        .bank_o       (bank_o),
        .addr_o       (addr_o),
        .done_o       (done_o)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Steps until the selected output is 1; n = cycles taken, -1 on timeout.
    task automatic wait_for(input int sel, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget && n < 0; i++) begin
            step();
            if ((sel == 0 && ddr_reset_n_o === 1'b1) ||
                (sel == 1 && enable_o === 1'b1) ||
                (sel == 2 && req_o === 1'b1) ||
                (sel == 3 && done_o === 1'b1))
                n = i;
        end
    endtask

    task automatic test_reset();
        logic [25:0] got;
        reset = 1'b1;
        accept_i = 1'b1;
        step();
        step();
        got = {ddr_reset_n_o, enable_o, req_o, command_o,
               bank_o, addr_o, done_o};
        checks++;
        if (got !== {3'b000, 4'b0111, 3'd0, 15'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", got,
                     {3'b000, 4'b0111, 3'd0, 15'd0, 1'b0});
        end
        reset = 1'b0;
    endtask

    task automatic test_power_up();
        int n;
        accept_i = 1'b1;
        wait_for(0, E_RST + 10, n);
        checks++;
        if (n !== E_RST) begin
            failures++;
            $display("FAIL reset_n_rise got=%0d exp=%0d", n, E_RST);
        end
        checks++;
        if (enable_o !== 1'b0) begin
            failures++;
            $display("FAIL cke_early got=%b exp=0", enable_o);
        end
        wait_for(1, E_CKE + 10, n);
        checks++;
        if (n !== E_CKE) begin
            failures++;
            $display("FAIL cke_rise got=%0d exp=%0d", n, E_CKE);
        end
        wait_for(2, E_XPR + 10, n);
        checks++;
        if (n !== E_XPR) begin
            failures++;
            $display("FAIL xpr_gap got=%0d exp=%0d", n, E_XPR);
        end
        checks++;
        if ({command_o, bank_o, addr_o} !== {4'b0000, 3'd2, 15'h0008}) begin
            failures++;
            $display("FAIL mr2_cmd got=%h/%0d/%h exp=0/2/0008",
                     command_o, bank_o, addr_o);
        end
    endtask

    // From MR2 on the port through to done_o.
    task automatic test_mrs_sequence();
        int n;
        accept_i = 1'b1;
        wait_for(2, 20, n);
        checks++;
        if (n !== 4 || {command_o, bank_o, addr_o} !== {4'b0000, 3'd3, 15'h0000}) begin
            failures++;
            $display("FAIL mr3 gap=%0d got=%h/%0d/%h exp=4 0/3/0000",
                     n, command_o, bank_o, addr_o);
        end
        wait_for(2, 20, n);
        checks++;
        if (n !== 4 || {command_o, bank_o, addr_o} !== {4'b0000, 3'd1, 15'h0004}) begin
            failures++;
            $display("FAIL mr1 gap=%0d got=%h/%0d/%h exp=4 0/1/0004",
                     n, command_o, bank_o, addr_o);
        end
        wait_for(2, 20, n);
        checks++;
        if (n !== 4 || {command_o, bank_o, addr_o} !== {4'b0000, 3'd0, 15'h0522}) begin
            failures++;
            $display("FAIL mr0 gap=%0d got=%h/%0d/%h exp=4 0/0/0522",
                     n, command_o, bank_o, addr_o);
        end
        wait_for(2, 30, n);
        checks++;
        if (n !== 12 || {command_o, bank_o, addr_o} !== {4'b0110, 3'd0, 15'h0400}) begin
            failures++;
            $display("FAIL zqcl gap=%0d got=%h/%0d/%h exp=12 6/0/0400",
                     n, command_o, bank_o, addr_o);
        end
        wait_for(3, E_ZQI + 10, n);
        checks++;
        if (n !== E_ZQI) begin
            failures++;
            $display("FAIL done_gap got=%0d exp=%0d", n, E_ZQI);
        end
        checks++;
        if ({ddr_reset_n_o, enable_o, req_o, command_o} !== {3'b110, 4'b0111}) begin
            failures++;
            $display("FAIL done_outputs got=%b exp=1100111",
                     {ddr_reset_n_o, enable_o, req_o, command_o});
        end
    endtask

    task automatic test_done_idle();
        for (int i = 0; i < 100; i++) begin
            accept_i = 1'($urandom_range(0, 1));
            step();
            checks++;
            if ({req_o, command_o, done_o} !== 6'b0_0111_1) begin
                failures++;
                $display("FAIL done_idle cyc=%0d got=%b exp=001111", i,
                         {req_o, command_o, done_o});
            end
        end
        accept_i = 1'b1;
    endtask

    // MR2 on the port on entry; MR3 is held off for 10 cycles.
    task automatic test_accept_stall();
        int n;
        int bad;
        step();
        accept_i = 1'b0;
        wait_for(2, 20, n);
        checks++;
        if (n !== 3 || bank_o !== 3'd3) begin
            failures++;
            $display("FAIL stall_mr3 gap=%0d bank=%0d exp=3 3", n, bank_o);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({req_o, command_o, bank_o, addr_o} !== {1'b1, 4'b0000, 3'd3, 15'd0})
                bad++;
            step();
        end
        checks++;
        if (bad !== 0 || {req_o, command_o, bank_o} !== {1'b1, 4'b0000, 3'd3}) begin
            failures++;
            $display("FAIL stall_hold bad=%0d got=%b/%h/%0d exp=0 1/0/3",
                     bad, req_o, command_o, bank_o);
        end
        accept_i = 1'b1;
        wait_for(2, 20, n);
        checks++;
        if (n !== 4 || {bank_o, addr_o} !== {3'd1, 15'h0004}) begin
            failures++;
            $display("FAIL stall_mr1 gap=%0d got=%0d/%h exp=4 1/0004",
                     n, bank_o, addr_o);
        end
    endtask

    // MR1 on the port on entry; reset lands inside the ZQCL wait.
    task automatic test_reset_mid();
        int n;
        logic [25:0] got;
        wait_for(2, 20, n);
        checks++;
        if (n !== 4 || addr_o !== 15'h0522) begin
            failures++;
            $display("FAIL mid_mr0 gap=%0d addr=%h exp=4 0522", n, addr_o);
        end
        wait_for(2, 30, n);
        checks++;
        if (n !== 12 || command_o !== 4'b0110) begin
            failures++;
            $display("FAIL mid_zqcl gap=%0d cmd=%b exp=12 0110", n, command_o);
        end
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        got = {ddr_reset_n_o, enable_o, req_o, command_o,
               bank_o, addr_o, done_o};
        checks++;
        if (got !== {3'b000, 4'b0111, 3'd0, 15'd0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=%h", got,
                     {3'b000, 4'b0111, 3'd0, 15'd0, 1'b0});
        end
        test_power_up();
        test_mrs_sequence();
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_mrs_sequence();
        test_done_idle();
        test_reset();
        test_power_up();
        test_accept_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
